// File: rtl/id_stage_fwdn.sv
// RV32I/M decode stage: IF->ID register, class/immediate decode,
// local register file, N-channel forwarding and optional branch resolve.
module id_stage_fwdn #(
  parameter int XLEN        = 32,
  parameter int NUM_FWD     = 3,
  parameter int BR_IN_ID    = 1,
  parameter int STALL_CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [XLEN-1:0]          if_pc,
  input  logic [31:0]              if_instr,
  output logic                     id_allow_in,
  input  logic                     ex_allow_in,
  input  logic                     flush,
  output logic                     ex_valid,
  output logic [XLEN-1:0]          ex_pc,
  output logic [XLEN-1:0]          ex_imm,
  output logic [XLEN-1:0]          ex_src1,
  output logic [XLEN-1:0]          ex_src2,
  output logic [31:0]              ex_instr,
  output logic [4:0]               ex_rd,
  output logic [8:0]               ex_cls,
  input  logic [NUM_FWD-1:0]       fwd_wen,
  input  logic [NUM_FWD-1:0]       fwd_rdy,
  input  logic [5*NUM_FWD-1:0]     fwd_addr,
  input  logic [XLEN*NUM_FWD-1:0]  fwd_data,
  input  logic                     wb_wen,
  input  logic [4:0]               wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  localparam int C_OPI  = 8;
  localparam int C_LUI  = 7;
  localparam int C_AUI  = 6;
  localparam int C_OPR  = 5;
  localparam int C_JAL  = 4;
  localparam int C_JALR = 3;
  localparam int C_BR   = 2;
  localparam int C_LD   = 1;
  localparam int C_ST   = 0;

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] rf [32];

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [8:0] cls;

  assign opc = id_instr[6:0];
  assign rd  = id_instr[11:7];
  assign f3  = id_instr[14:12];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign f7  = id_instr[31:25];

  always_comb begin
    cls = '0;
    case (opc)
      7'b0010011:
        cls[C_OPI] = (f3 == 3'b001) ? (f7 == 7'h00) :
                     (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) :
                     1'b1;
      7'b0110111: cls[C_LUI] = 1'b1;
      7'b0010111: cls[C_AUI] = 1'b1;
      7'b0110011:
        cls[C_OPR] = (f7 == 7'h00) || (f7 == 7'h01) ||
                     (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      7'b1101111: cls[C_JAL]  = 1'b1;
      7'b1100111: cls[C_JALR] = (f3 == 3'b000);
      7'b1100011: cls[C_BR]   = (f3 != 3'b010) && (f3 != 3'b011);
      7'b0000011:
        cls[C_LD] = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      7'b0100011: cls[C_ST] = (f3 <= 3'b010);
      default: ;
    endcase
  end

  logic is_i;
  logic is_u;
  logic [XLEN-1:0] imm;

  assign is_i = cls[C_OPI] | cls[C_JALR] | cls[C_LD];
  assign is_u = cls[C_LUI] | cls[C_AUI];

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_i:
        imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
      cls[C_ST]:
        imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:25],
               id_instr[11:7]};
      cls[C_BR]:
        imm = {{(XLEN-13){id_instr[31]}}, id_instr[31], id_instr[7],
               id_instr[30:25], id_instr[11:8], 1'b0};
      is_u:
        imm = {{(XLEN-32){id_instr[31]}}, id_instr[31:12], 12'h000};
      cls[C_JAL]:
        imm = {{(XLEN-21){id_instr[31]}}, id_instr[31],
               id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
      default: ;
    endcase
  end

  logic use1;
  logic use2;
  logic haz1;
  logic haz2;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;

  assign use1 = cls[C_OPI] | cls[C_OPR] | cls[C_JALR] |
                cls[C_BR] | cls[C_LD] | cls[C_ST];
  assign use2 = cls[C_OPR] | cls[C_ST] | cls[C_BR];

  // Scan oldest to youngest so the youngest matching channel wins.
  always_comb begin
    src1 = (wb_wen && wb_addr == rs1) ? wb_data : rf[rs1];
    src2 = (wb_wen && wb_addr == rs2) ? wb_data : rf[rs2];
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_wen[k] && fwd_addr[5*k +: 5] == rs1) begin
        src1 = fwd_data[XLEN*k +: XLEN];
        haz1 = ~fwd_rdy[k];
      end
      if (fwd_wen[k] && fwd_addr[5*k +: 5] == rs2) begin
        src2 = fwd_data[XLEN*k +: XLEN];
        haz2 = ~fwd_rdy[k];
      end
    end
    if (rs1 == 5'd0) begin
      src1 = '0;
      haz1 = 1'b0;
    end
    if (rs2 == 5'd0) begin
      src2 = '0;
      haz2 = 1'b0;
    end
  end

  logic id_ready;
  logic fire;

  assign id_ready    = ~(use1 & haz1) & ~(use2 & haz2);
  assign fire        = id_valid & id_ready & ex_allow_in;
  assign id_allow_in = ~id_valid | (id_ready & ex_allow_in);

  logic br_eq;
  logic br_lt;
  logic br_ltu;
  logic br_take;
  logic [XLEN-1:0] pc_tgt;
  logic [XLEN-1:0] jr_tgt;
  logic jump_take;

  assign br_eq  = (src1 == src2);
  assign br_lt  = ($signed(src1) < $signed(src2));
  assign br_ltu = (src1 < src2);

  always_comb begin
    br_take = 1'b0;
    case (f3)
      3'b000:  br_take = br_eq;
      3'b001:  br_take = ~br_eq;
      3'b100:  br_take = br_lt;
      3'b101:  br_take = ~br_lt;
      3'b110:  br_take = br_ltu;
      3'b111:  br_take = ~br_ltu;
      default: br_take = 1'b0;
    endcase
  end

  assign pc_tgt = id_pc + imm;
  assign jr_tgt = (src1 + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
  assign jump_take = cls[C_JAL] | cls[C_JALR] | (cls[C_BR] & br_take);

  assign redirect_valid = (BR_IN_ID != 0) & fire & jump_take;
  assign redirect_pc    = cls[C_JALR] ? jr_tgt : pc_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (fire && redirect_valid) begin
      // The IF entry behind a taken redirect is wrong-path.
      id_valid <= 1'b0;
    end else if (id_allow_in) begin
      id_valid <= if_valid;
      if (if_valid) begin
        id_pc    <= if_pc;
        id_instr <= if_instr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else if (wb_wen && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (id_valid && !id_ready && !flush && !(&stall_cnt))
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  assign ex_valid = id_valid & id_ready;
  assign ex_pc    = id_pc;
  assign ex_imm   = imm;
  assign ex_src1  = src1;
  assign ex_src2  = src2;
  assign ex_instr = id_instr;
  assign ex_cls   = cls;
  assign ex_rd    = (is_u | cls[C_OPI] | cls[C_OPR] | cls[C_JAL] |
                     cls[C_JALR] | cls[C_LD]) ? rd : 5'd0;

endmodule

// File: tb/tb_id_stage_fwdn.sv
// Directed bench for id_stage_fwdn: bypass, forwarding stalls,
// branch/jump redirects, flush and asynchronous reset.
module tb_id_stage_fwdn;
  localparam int XLEN = 32;
  localparam int NF   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic [31:0]     if_pc;
  logic [31:0]     if_instr;
  logic            id_allow_in;
  logic            ex_allow_in;
  logic            flush;
  logic            ex_valid;
  logic [31:0]     ex_pc;
  logic [31:0]     ex_imm;
  logic [31:0]     ex_src1;
  logic [31:0]     ex_src2;
  logic [31:0]     ex_instr;
  logic [4:0]      ex_rd;
  logic [8:0]      ex_cls;
  logic [NF-1:0]   fwd_wen;
  logic [NF-1:0]   fwd_rdy;
  logic [5*NF-1:0] fwd_addr;
  logic [32*NF-1:0] fwd_data;
  logic            wb_wen;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic [31:0]     stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_stage_fwdn #(
    .XLEN(XLEN), .NUM_FWD(NF), .BR_IN_ID(1), .STALL_CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_allow_in(id_allow_in), .ex_allow_in(ex_allow_in),
    .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_instr(ex_instr), .ex_rd(ex_rd), .ex_cls(ex_cls),
    .fwd_wen(fwd_wen), .fwd_rdy(fwd_rdy), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .wb_wen(wb_wen), .wb_addr(wb_addr),
    .wb_data(wb_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] im,
      input logic [4:0] r1, input logic [2:0] f3,
      input logic [4:0] rdd, input logic [6:0] op);
    return {im, r1, f3, rdd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] im,
      input logic [4:0] r2, input logic [4:0] r1,
      input logic [2:0] f3);
    return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] im,
      input logic [4:0] rdd);
    return {im[20], im[10:1], im[11], im[19:12], rdd, 7'h6f};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    step();
    if_valid = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_wen  = 1'b1;
    wb_addr = a;
    wb_data = d;
    step();
    wb_wen  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_valid = 0; if_pc = 0; if_instr = 0;
    ex_allow_in = 1'b1; flush = 0;
    fwd_wen = 0; fwd_rdy = 0; fwd_addr = 0; fwd_data = 0;
    wb_wen = 0; wb_addr = 0; wb_data = 0;
    #12;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_cls", {23'd0, ex_cls}, 32'd0);
    chk("rst_allow_in", {31'd0, id_allow_in}, 32'd1);
    rst = 1'b0;
    step();

    // add x6,x5,x0 with same-cycle WB of x5
    load(32'h0002_8333, 32'h40);
    wb_wen = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    @(negedge clk);
    chk("wt_src1", ex_src1, 32'h1234);
    chk("wt_valid", {31'd0, ex_valid}, 32'd1);
    chk("wt_rd", {27'd0, ex_rd}, 32'd6);
    chk("wt_cls", {23'd0, ex_cls}, 32'h020);
    step();
    wb_wen = 1'b0;

    // addi x1,x5,1: youngest channel not ready, older one ready
    fwd_wen = 3'b011; fwd_rdy = 3'b010;
    fwd_addr = {5'd0, 5'd5, 5'd5};
    fwd_data = {32'd0, 32'd7, 32'd0};
    load(enc_i(12'd1, 5'd5, 3'd0, 5'd1, 7'h13), 32'h44);
    @(negedge clk);
    chk("stall_valid", {31'd0, ex_valid}, 32'd0);
    chk("stall_allow", {31'd0, id_allow_in}, 32'd0);
    chk("stall_cnt0", stall_cnt, 32'd0);
    step();
    chk("stall_cnt1", stall_cnt, 32'd1);
    step();
    step();
    fwd_rdy = 3'b011;
    fwd_data = {32'd0, 32'd7, 32'd9};
    @(negedge clk);
    chk("fwd_cnt3", stall_cnt, 32'd3);
    chk("fwd_valid", {31'd0, ex_valid}, 32'd1);
    chk("fwd_src1", ex_src1, 32'd9);
    chk("fwd_imm", ex_imm, 32'd1);
    step();
    fwd_wen = 3'b000; fwd_rdy = 3'b000;
    @(negedge clk);
    chk("fire_empty", {31'd0, ex_valid}, 32'd0);
    chk("fire_cnt", stall_cnt, 32'd3);

    // beq x1,x2,-8 at 0x100, taken
    step();
    wr(5'd1, 32'd3);
    wr(5'd2, 32'd3);
    load(enc_b(-13'sd8, 5'd2, 5'd1, 3'd0), 32'h100);
    if_valid = 1'b1;
    if_instr = enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13);
    if_pc = 32'h104;
    @(negedge clk);
    chk("beq_redir", {31'd0, redirect_valid}, 32'd1);
    chk("beq_pc", redirect_pc, 32'hF8);
    chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
    chk("beq_rd", {27'd0, ex_rd}, 32'd0);
    chk("beq_allow", {31'd0, id_allow_in}, 32'd1);
    step();
    if_valid = 1'b0;
    @(negedge clk);
    chk("beq_redir1", {31'd0, redirect_valid}, 32'd0);
    chk("beq_drop", {31'd0, ex_valid}, 32'd0);

    // beq not taken
    step();
    wr(5'd2, 32'd4);
    load(enc_b(-13'sd8, 5'd2, 5'd1, 3'd0), 32'h100);
    @(negedge clk);
    chk("bnt_redir", {31'd0, redirect_valid}, 32'd0);
    chk("bnt_valid", {31'd0, ex_valid}, 32'd1);
    step();

    // jalr x1,4(x2)
    wr(5'd2, 32'h2003);
    load(enc_i(12'd4, 5'd2, 3'd0, 5'd1, 7'h67), 32'h180);
    @(negedge clk);
    chk("jalr_redir", {31'd0, redirect_valid}, 32'd1);
    chk("jalr_pc", redirect_pc, 32'h2006);
    chk("jalr_rd", {27'd0, ex_rd}, 32'd1);
    step();

    // blt x3,x1,+16 signed (-1 < 3) and bltu (not taken)
    wr(5'd3, 32'hFFFF_FFFF);
    load(enc_b(13'd16, 5'd1, 5'd3, 3'd4), 32'h200);
    @(negedge clk);
    chk("blt_redir", {31'd0, redirect_valid}, 32'd1);
    chk("blt_pc", redirect_pc, 32'h210);
    step();
    load(enc_b(13'd16, 5'd1, 5'd3, 3'd6), 32'h200);
    @(negedge clk);
    chk("bltu_redir", {31'd0, redirect_valid}, 32'd0);
    chk("bltu_valid", {31'd0, ex_valid}, 32'd1);
    step();

    // jal x1,+0x800 at 0x300
    load(enc_j(21'h800, 5'd1), 32'h300);
    @(negedge clk);
    chk("jal_pc", redirect_pc, 32'hB00);
    chk("jal_imm", ex_imm, 32'h800);
    chk("jal_cls", {23'd0, ex_cls}, 32'h010);
    step();

    // lw x7,0(x0) held by EX, then flushed
    ex_allow_in = 1'b0;
    load(enc_i(12'd0, 5'd0, 3'd2, 5'd7, 7'h03), 32'h400);
    @(negedge clk);
    chk("lw_valid", {31'd0, ex_valid}, 32'd1);
    chk("lw_allow", {31'd0, id_allow_in}, 32'd0);
    chk("lw_cls", {23'd0, ex_cls}, 32'h002);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    ex_allow_in = 1'b1;
    @(negedge clk);
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_cnt", stall_cnt, 32'd3);

    // Async reset in the middle of a stall
    step();
    wr(5'd5, 32'h55);
    fwd_wen = 3'b001; fwd_rdy = 3'b000;
    fwd_addr = {5'd0, 5'd0, 5'd5};
    load(enc_i(12'd1, 5'd5, 3'd0, 5'd1, 7'h13), 32'h500);
    step();
    step();
    @(negedge clk);
    chk("pre_rst_cnt", stall_cnt, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_redir", {31'd0, redirect_valid}, 32'd0);
    chk("arst_cnt", stall_cnt, 32'd0);
    #1 rst = 1'b0;
    fwd_wen = 3'b000;
    step();
    load(32'h0002_8333, 32'h600);
    @(negedge clk);
    chk("arst_x5", ex_src1, 32'd0);
    chk("arst_x5v", {31'd0, ex_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
